// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: round-robin Wishbone-classic arbiter sharing one memory slave between fetch and data masters,
// with per-transfer ack timeout reporting.
module mem_bus_arbiter #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_cyc_i,
  input  logic              i_stb_i,
  input  logic [ADDR_W-1:0] i_adr_i,
  output logic [DATA_W-1:0] i_dat_o,
  output logic              i_ack_o,
  output logic              i_err_o,
  input  logic              d_cyc_i,
  input  logic              d_stb_i,
  input  logic              d_we_i,
  input  logic [ADDR_W-1:0] d_adr_i,
  input  logic [DATA_W-1:0] d_dat_i,
  output logic [DATA_W-1:0] d_dat_o,
  output logic              d_ack_o,
  output logic              d_err_o,
  output logic              m_cyc_o,
  output logic              m_stb_o,
  output logic              m_we_o,
  output logic [ADDR_W-1:0] m_adr_o,
  output logic [DATA_W-1:0] m_dat_o,
  input  logic [DATA_W-1:0] m_dat_i,
  input  logic              m_ack_i,
  output logic [1:0]        gnt_o
);
  localparam int CW = $clog2(TIMEOUT + 1);
  // State encoding doubles as the grant vector.
  typedef enum logic [1:0] {IDLE = 2'b00, GNT_I = 2'b01, GNT_D = 2'b10} state_t;
  state_t state_q, state_d;
  logic last_q, last_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic own_cyc, own_stb, act, ack, tmo;
  always_comb begin
    own_cyc = state_q == GNT_I ? i_cyc_i : state_q == GNT_D ? d_cyc_i : 1'b0;
    own_stb = state_q == GNT_I ? i_stb_i : state_q == GNT_D ? d_stb_i : 1'b0;
    act     = own_cyc & own_stb;
    ack     = act & m_ack_i;
    tmo     = act & ~m_ack_i & (cnt_q == CW'(TIMEOUT - 1));
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      last_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end
  // last_q: 0 = instruction master owned last, 1 = data master.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    if (state_q == IDLE) begin
      if (i_cyc_i & d_cyc_i) state_d = last_q ? GNT_I : GNT_D;
      else if (i_cyc_i)      state_d = GNT_I;
      else if (d_cyc_i)      state_d = GNT_D;
      if (state_d != IDLE) last_d = state_d == GNT_D;
    end else if (~own_cyc | tmo) begin
      state_d = IDLE;
    end
    cnt_d = (state_d != state_q || !act || m_ack_i) ? '0 :
            (cnt_q == CW'(TIMEOUT)) ? cnt_q : cnt_q + 1'b1;
  end
  always_comb begin
    gnt_o   = state_q;
    m_cyc_o = own_cyc;
    m_stb_o = act & ~tmo;
    m_we_o  = state_q == GNT_D & d_we_i;
    m_adr_o = state_q == GNT_I ? i_adr_i : state_q == GNT_D ? d_adr_i : '0;
    m_dat_o = state_q == GNT_D ? d_dat_i : '0;
    i_ack_o = ack & (state_q == GNT_I);
    d_ack_o = ack & (state_q == GNT_D);
    i_err_o = tmo & (state_q == GNT_I);
    d_err_o = tmo & (state_q == GNT_D);
    i_dat_o = m_dat_i;
    d_dat_o = m_dat_i;
  end
endmodule
